// File: rtl/rs_decode_ctrl.sv
// rs_decode_ctrl: sequencing controller for the RS(15,11) decoder front end.
// Accepts a serial GF(16) symbol stream, steers the shared syndrome-unit
// load/accumulate control, evaluates the all-zero-syndrome flag after each
// codeword and either flags it clean or hands the syndromes to the KES,
// guarding the KES wait with a watchdog.
module rs_decode_ctrl #(
  parameter int N           = 15,
  parameter int SYM_W       = 4,
  parameter int NSYN        = 4,
  parameter int KES_TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_symbol,
  output logic             in_ready,
  output logic [SYM_W-1:0] syn_in,
  output logic [NSYN-1:0]  syn_control,
  input  logic             syn_zero,
  output logic             syn_valid,
  output logic             kes_start,
  input  logic             kes_done,
  output logic             cw_clean,
  output logic             err_abort,
  output logic             err_timeout,
  output logic [7:0]       cw_count
);

  // Last symbol index within a codeword and last watchdog count before timeout.
  localparam logic [3:0] CNT_LAST  = 4'(N - 1);
  localparam logic [5:0] WDOG_LAST = 6'(KES_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EVAL,
    ST_KES_WAIT
  } state_t;

  state_t     state;
  logic [3:0] sym_cnt;
  logic [5:0] wdog;

  // Symbols go straight through to the syndrome units; the controller only
  // decides whether they load or accumulate.
  assign syn_in = in_symbol;

  // Main sequencer: symbol counting, EVAL decision, KES wait with watchdog,
  // and the completed-codeword counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      sym_cnt  <= 4'd0;
      wdog     <= 6'd0;
      cw_count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          // First symbol of a codeword is loaded (syn_control = 0 here).
          if (in_valid) begin
            sym_cnt <= 4'd1;
            state   <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (in_valid) begin
            if (sym_cnt == CNT_LAST) begin
              sym_cnt <= 4'd0;
              state   <= ST_EVAL;
            end else begin
              sym_cnt <= sym_cnt + 4'd1;
            end
          end else begin
            // Upstream stalled mid-codeword: drop the partial codeword.
            sym_cnt <= 4'd0;
            state   <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          cw_count <= cw_count + 8'd1;
          if (syn_zero) begin
            state <= ST_IDLE;
          end else begin
            wdog  <= 6'd0;
            state <= ST_KES_WAIT;
          end
        end
        ST_KES_WAIT: begin
          // Completion takes priority over a coincident timeout.
          if (kes_done) begin
            wdog  <= 6'd0;
            state <= ST_IDLE;
          end else if (wdog == WDOG_LAST) begin
            wdog  <= 6'd0;
            state <= ST_IDLE;
          end else begin
            wdog <= wdog + 6'd1;
          end
        end
        default: begin
          sym_cnt <= 4'd0;
          wdog    <= 6'd0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and syndrome-unit mode; ready is held low while in reset.
  always_comb begin
    in_ready    = 1'b0;
    syn_control = '0;
    case (state)
      ST_IDLE: begin
        in_ready    = reset_n;
        syn_control = '0;
      end
      ST_COLLECT: begin
        in_ready    = reset_n;
        syn_control = {NSYN{1'b1}};
      end
      default: begin
        in_ready    = 1'b0;
        syn_control = '0;
      end
    endcase
  end

  // Status pulses decoded from state and inputs; only syn_valid may overlap
  // with kes_start or cw_clean.
  always_comb begin
    syn_valid   = (state == ST_EVAL);
    cw_clean    = (state == ST_EVAL) && syn_zero;
    kes_start   = (state == ST_EVAL) && !syn_zero;
    err_abort   = (state == ST_COLLECT) && !in_valid;
    err_timeout = (state == ST_KES_WAIT) && !kes_done && (wdog == WDOG_LAST);
  end

endmodule

// File: tb/tb_rs_decode_ctrl.sv
// tb_rs_decode_ctrl: directed bench for rs_decode_ctrl with an event
// scoreboard; expected pulses are queued as stimulus is driven and matched
// against the DUT's status outputs on the falling clock edge.
module tb_rs_decode_ctrl;

  localparam int EV_NONE    = 0;
  localparam int EV_CLEAN   = 1;
  localparam int EV_KES     = 2;
  localparam int EV_ABORT   = 3;
  localparam int EV_TIMEOUT = 4;
  localparam int EV_BAD     = 9;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] cw;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [3:0] in_symbol;
  logic       in_ready;
  logic [3:0] syn_in;
  logic [3:0] syn_control;
  logic       syn_zero;
  logic       syn_valid;
  logic       kes_start;
  logic       kes_done;
  logic       cw_clean;
  logic       err_abort;
  logic       err_timeout;
  logic [7:0] cw_count;

  int         total  = 0;
  int         passed = 0;
  int         fails  = 0;
  int         cyc    = 0;
  logic [7:0] exp_cw = 8'd0;
  evt_t       sb[$];
  int         mon_kind;
  evt_t       mon_e;
  int         c0;
  int         cbase;

  logic [3:0] cw_syms [15] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd11, 4'd7, 4'd8,
                               4'd9, 4'd10, 4'd11, 4'd3, 4'd1, 4'd12, 4'd12};

  rs_decode_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_symbol   (in_symbol),
    .in_ready    (in_ready),
    .syn_in      (syn_in),
    .syn_control (syn_control),
    .syn_zero    (syn_zero),
    .syn_valid   (syn_valid),
    .kes_start   (kes_start),
    .kes_done    (kes_done),
    .cw_clean    (cw_clean),
    .err_abort   (err_abort),
    .err_timeout (err_timeout),
    .cw_count    (cw_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_evt(input int kind, input int c, input logic [7:0] cw);
    evt_t e;
    e.kind = kind;
    e.cyc  = c;
    e.cw   = cw;
    sb.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives nsym symbols back to back, one per cycle, starting this cycle.
  task automatic send_stream(input int nsym, input bit chk);
    for (int i = 0; i < nsym; i++) begin
      in_symbol = cw_syms[i];
      in_valid  = 1'b1;
      if (chk) begin
        #3;
        check("sym_ready", in_ready, 1);
        check("sym_ctrl", syn_control, (i == 0) ? 4'h0 : 4'hF);
        check("syn_in", syn_in, cw_syms[i]);
      end
      next_cyc();
    end
  endtask

  // Scoreboard monitor: any status pulse must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && (cw_clean | kes_start | err_abort | err_timeout | syn_valid)) begin
      case ({err_timeout, err_abort, kes_start, cw_clean})
        4'b0001: mon_kind = EV_CLEAN;
        4'b0010: mon_kind = EV_KES;
        4'b0100: mon_kind = EV_ABORT;
        4'b1000: mon_kind = EV_TIMEOUT;
        default: mon_kind = EV_BAD;
      endcase
      if (sb.size() == 0) begin
        check("unexpected_evt", mon_kind, EV_NONE);
      end else begin
        mon_e = sb.pop_front();
        check("evt_kind", mon_kind, mon_e.kind);
        check("evt_cycle", cyc, mon_e.cyc);
        check("evt_syn_valid", syn_valid, (mon_e.kind == EV_CLEAN) || (mon_e.kind == EV_KES));
        check("evt_cw_count", cw_count, mon_e.cw);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_symbol = 4'd0;
    syn_zero  = 1'b0;
    kes_done  = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_syn_ctrl", syn_control, 0);
    check("rst_cw_count", cw_count, 0);
    check("rst_pulses", {syn_valid, kes_start, cw_clean, err_abort, err_timeout}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cyc();

    // Clean codeword
    syn_zero = 1'b1;
    cbase = cyc;
    push_evt(EV_CLEAN, cbase + 15, exp_cw);
    exp_cw++;
    send_stream(15, 1'b1);
    in_valid = 1'b0;
    #3;
    check("eval_ready_lo", in_ready, 0);
    next_cyc();
    #3;
    check("clean_ready_hi", in_ready, 1);
    check("clean_cw_count", cw_count, exp_cw);
    next_cyc();

    // Failed codeword, KES returns 5 cycles after start
    syn_zero = 1'b0;
    cbase = cyc;
    push_evt(EV_KES, cbase + 15, exp_cw);
    exp_cw++;
    send_stream(15, 1'b0);
    in_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j == 5) kes_done = 1'b1;
      #3;
      check("kes_ready_lo", in_ready, 0);
      next_cyc();
    end
    kes_done = 1'b0;
    #3;
    check("kes_ready_hi", in_ready, 1);
    check("kes_cw_count", cw_count, exp_cw);
    next_cyc();

    // Abort after 7 symbols, then a full codeword
    syn_zero = 1'b1;
    cbase = cyc;
    send_stream(7, 1'b1);
    in_valid = 1'b0;
    push_evt(EV_ABORT, cbase + 7, exp_cw);
    next_cyc();
    #3;
    check("abort_cw_count", cw_count, exp_cw);
    next_cyc();
    cbase = cyc;
    push_evt(EV_CLEAN, cbase + 15, exp_cw);
    exp_cw++;
    send_stream(15, 1'b1);
    in_valid = 1'b0;
    next_cyc();

    // KES never finishes: timeout 63 cycles after start
    syn_zero = 1'b0;
    cbase = cyc;
    push_evt(EV_KES, cbase + 15, exp_cw);
    exp_cw++;
    push_evt(EV_TIMEOUT, cbase + 15 + 63, exp_cw);
    send_stream(15, 1'b0);
    in_valid = 1'b0;
    repeat (64) next_cyc();
    #3;
    check("tmo_ready_hi", in_ready, 1);
    next_cyc();

    // KES done on the timeout cycle: no timeout pulse
    cbase = cyc;
    push_evt(EV_KES, cbase + 15, exp_cw);
    exp_cw++;
    send_stream(15, 1'b0);
    in_valid = 1'b0;
    repeat (63) next_cyc();
    kes_done = 1'b1;
    #3;
    check("tie_no_timeout", err_timeout, 0);
    next_cyc();
    kes_done = 1'b0;
    #3;
    check("tie_ready_hi", in_ready, 1);
    check("tie_cw_count", cw_count, exp_cw);
    next_cyc();

    // Asynchronous reset during symbol 10
    syn_zero = 1'b1;
    send_stream(9, 1'b0);
    in_symbol = cw_syms[9];
    in_valid  = 1'b1;
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    exp_cw   = 8'd0;
    #1;
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_ctrl", syn_control, 0);
    check("mid_rst_cw_count", cw_count, exp_cw);
    #1;
    reset_n = 1'b1;
    next_cyc();
    cbase = cyc;
    push_evt(EV_CLEAN, cbase + 15, exp_cw);
    exp_cw++;
    send_stream(15, 1'b1);
    in_valid = 1'b0;
    next_cyc();
    #3;
    check("post_rst_cw_count", cw_count, exp_cw);

    // 256 back-to-back clean codewords from a fresh reset
    next_cyc();
    #1;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    exp_cw  = 8'd0;
    next_cyc();
    c0 = cyc;
    for (int k = 0; k < 256; k++) begin
      push_evt(EV_CLEAN, c0 + 16 * k + 15, exp_cw);
      exp_cw++;
      send_stream(15, 1'b0);
      in_valid = 1'b0;
      next_cyc();
    end
    #3;
    check("wrap_cw_count", cw_count, exp_cw);
    check("wrap_ready_hi", in_ready, 1);
    next_cyc();

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
